// File: rtl/regfile_mm_acc.sv
// Operand/accumulator register file for the matrix-multiply datapath.
// Lane-masked overwrite/accumulate writes, accumulator clear and counter, one registered read port.
module regfile_mm_acc #(
    parameter int NUM_REGS = 3,
    parameter int DATA_W   = 256,
    parameter int LANE_W   = 16,
    parameter int ACC_IDX  = 2,
    parameter int SAT      = 0,
    localparam int LANES   = DATA_W / LANE_W,
    localparam int AW      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we_rf,
    input  logic [AW-1:0]                rd_rf,
    input  logic                         wmode,
    input  logic [LANES-1:0]             wmask,
    input  logic [DATA_W-1:0]            wdata_mm,
    input  logic                         stc,
    input  logic [AW-1:0]                raddr,
    output logic [DATA_W-1:0]            rdata,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          valid,
    output logic [7:0]                   acc_cnt,
    output logic                         err
);

    // NOTE: the register file is built from flops, not a RAM, so every entry is reset explicitly.
    logic [DATA_W-1:0]   r_regs [NUM_REGS] = '{default: '0};
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REGS-1:0] r_valid;
    logic [7:0]          r_acc_cnt;
    logic                r_err;

    logic                w_in_range;
    logic                w_to_acc;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_new;
    logic [DATA_W-1:0]   w_rd_val;

    // Signed lane add; with SAT set, overflow is detected by the two top sum bits disagreeing.
    function automatic logic [LANE_W-1:0] f_lane_acc(input logic [LANE_W-1:0] a,
                                                     input logic [LANE_W-1:0] b);
        logic [LANE_W:0] s;
        s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        if (SAT != 0 && (s[LANE_W] != s[LANE_W-1])) begin
            return s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end
        return s[LANE_W-1:0];
    endfunction

    assign w_in_range = ({1'b0, rd_rf} < (AW+1)'(NUM_REGS));
    assign w_to_acc   = (rd_rf == AW'(ACC_IDX));
    assign w_wr_en    = we_rf && w_in_range && (|wmask) && !(stc && w_to_acc);

    always_comb begin
        w_old    = '0;
        w_rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_rf == AW'(k)) w_old = r_regs[k];
            if (raddr == AW'(k)) w_rd_val = r_regs[k];
        end
    end

    always_comb begin
        w_new = w_old;
        for (int i = 0; i < LANES; i++) begin
            if (wmask[i]) begin
                w_new[i*LANE_W +: LANE_W] = wmode
                    ? f_lane_acc(w_old[i*LANE_W +: LANE_W], wdata_mm[i*LANE_W +: LANE_W])
                    : wdata_mm[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
            r_rdata   <= '0;
            r_valid   <= '0;
            r_acc_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err   <= we_rf && !w_in_range;
            r_rdata <= w_rd_val;
            if (w_wr_en) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (rd_rf == AW'(k)) begin
                        r_regs[k]  <= w_new;
                        r_valid[k] <= 1'b1;
                    end
                end
                if (w_to_acc) begin
                    r_acc_cnt <= !wmode ? 8'd0 : (r_acc_cnt == 8'hFF) ? 8'hFF : r_acc_cnt + 8'd1;
                end
            end
            // Clear wins over anything above that targeted the accumulator.
            if (stc) begin
                r_regs[ACC_IDX]  <= '0;
                r_valid[ACC_IDX] <= 1'b0;
                r_acc_cnt        <= '0;
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NUM_REGS; k++) regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
    end

    assign rdata   = r_rdata;
    assign valid   = r_valid;
    assign acc_cnt = r_acc_cnt;
    assign err     = r_err;

endmodule
